// File: rtl/zigzag_rle_encoder_if.sv
// Block-in / symbol-out stream bundle for the zig-zag run-length encoder.
// Both streams transfer on a rising clock edge where valid && ready; valid never waits on ready.
interface zigzag_rle_encoder_if #(
    parameter int COEFF_W     = 16,
    parameter int NUM_SAMPLES = 64
);
    logic [COEFF_W*NUM_SAMPLES-1:0] block_in;
    logic                           block_valid;
    logic                           block_ready;
    logic [3:0]                     sym_run;
    logic [COEFF_W-1:0]             sym_value;
    logic                           sym_eob;
    logic                           sym_valid;
    logic                           sym_ready;

    modport slave (
        input  block_in, block_valid, sym_ready,
        output block_ready, sym_run, sym_value, sym_eob, sym_valid
    );

    modport master (
        output block_in, block_valid, sym_ready,
        input  block_ready, sym_run, sym_value, sym_eob, sym_valid
    );
endinterface

// File: rtl/zigzag_rle_encoder.sv
// Turns one zig-zag ordered 64-coefficient block into JPEG-style (run, value) symbols:
// DC, AC, ZRL and a closing EOB, on a valid/ready stream with full backpressure.
module zigzag_rle_encoder #(
    parameter int COEFF_W     = 16,
    parameter int NUM_SAMPLES = 64,
    parameter int MAX_RUN     = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    zigzag_rle_encoder_if.slave        bus,
    output logic                       done,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        EOB_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_RUN);

    state_t                                 state_q, state_d;
    logic [NUM_SAMPLES-1:0][COEFF_W-1:0]    coef_q, coef_d;
    logic [6:0]                             idx_q, idx_d;
    logic [3:0]                             run_q, run_d;
    logic [3:0]                             sym_run_q, sym_run_d;
    logic [COEFF_W-1:0]                     sym_value_q, sym_value_d;
    logic                                   sym_eob_q, sym_eob_d;
    logic                                   sym_valid_q, sym_valid_d;
    logic                                   done_q, done_d;
    logic                                   busy_q, busy_d;

    logic [6:0]                             last_nz;
    logic [COEFF_W-1:0]                     cur_coef;
    logic                                   slot_free;

    // Highest nonzero AC position; 0 means the block has no AC content at all.
    always_comb begin
        last_nz = '0;
        for (int k = 1; k < NUM_SAMPLES; k++) begin
            if (coef_q[k[5:0]] != '0) last_nz = 7'(k);
        end
    end

    assign cur_coef  = coef_q[idx_q[5:0]];
    assign slot_free = !sym_valid_q || bus.sym_ready;

    always_comb begin
        state_d     = state_q;
        coef_d      = coef_q;
        idx_d       = idx_q;
        run_d       = run_q;
        sym_run_d   = sym_run_q;
        sym_value_d = sym_value_q;
        sym_eob_d   = sym_eob_q;
        sym_valid_d = sym_valid_q && !bus.sym_ready;
        done_d      = 1'b0;
        busy_d      = busy_q;

        unique case (state_q)
            IDLE: begin
                if (bus.block_valid) begin
                    coef_d      = bus.block_in;
                    sym_run_d   = '0;
                    sym_value_d = bus.block_in[COEFF_W-1:0];
                    sym_eob_d   = 1'b0;
                    sym_valid_d = 1'b1;
                    idx_d       = 7'd1;
                    run_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = SCAN;
                end
            end

            SCAN: begin
                if (enable && slot_free) begin
                    if (idx_q > last_nz) begin
                        sym_run_d   = '0;
                        sym_value_d = '0;
                        sym_eob_d   = 1'b1;
                        sym_valid_d = 1'b1;
                        state_d     = EOB_HOLD;
                    end else if (cur_coef != '0) begin
                        sym_run_d   = run_q;
                        sym_value_d = cur_coef;
                        sym_eob_d   = 1'b0;
                        sym_valid_d = 1'b1;
                        run_d       = '0;
                        idx_d       = idx_q + 7'd1;
                    end else if (run_q == RUN_MAX) begin
                        // This zero is the 16th in a row: emit ZRL for the whole group.
                        sym_run_d   = RUN_MAX;
                        sym_value_d = '0;
                        sym_eob_d   = 1'b0;
                        sym_valid_d = 1'b1;
                        run_d       = '0;
                        idx_d       = idx_q + 7'd1;
                    end else begin
                        run_d       = run_q + 4'd1;
                        idx_d       = idx_q + 7'd1;
                    end
                end
            end

            EOB_HOLD: begin
                if (sym_valid_q && bus.sym_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            coef_q      <= '0;
            idx_q       <= '0;
            run_q       <= '0;
            sym_run_q   <= '0;
            sym_value_q <= '0;
            sym_eob_q   <= 1'b0;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            sym_run_q   <= sym_run_d;
            sym_value_q <= sym_value_d;
            sym_eob_q   <= sym_eob_d;
            sym_valid_q <= sym_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.block_ready = (state_q == IDLE);
    assign bus.sym_run     = sym_run_q;
    assign bus.sym_value   = sym_value_q;
    assign bus.sym_eob     = sym_eob_q;
    assign bus.sym_valid   = sym_valid_q;
    assign done            = done_q;
    assign busy            = busy_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Directed bench for zigzag_rle_encoder: hand-computed symbol lists go into an expected
// queue, a negedge monitor pops and compares every accepted symbol and its timing.
module tb_zigzag_rle_encoder;
  localparam int COEFF_W     = 16;
  localparam int NUM_SAMPLES = 64;
  localparam int BW          = COEFF_W * NUM_SAMPLES;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic       done;
  logic       busy;
  logic [1:0] dbg_state;

  zigzag_rle_encoder_if #(.COEFF_W(COEFF_W), .NUM_SAMPLES(NUM_SAMPLES)) bus ();

  zigzag_rle_encoder #(.COEFF_W(COEFF_W), .NUM_SAMPLES(NUM_SAMPLES), .MAX_RUN(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bus       (bus.slave),
    .done      (done),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [20:0] exp_q[$];
  int          acc_cyc_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        rdy_at_done = 1'b0;
  logic        busy_at_done = 1'b1;
  logic        held = 1'b0;
  logic [20:0] held_sym = '0;
  logic        bp_mode = 1'b0;
  int          hold_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] sym(input logic eob, input logic [3:0] run, input logic [15:0] val);
    return {eob, run, val};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        rdy_at_done  = bus.block_ready;
        busy_at_done = busy;
      end
      if (held)
        check("hold_stable", {bus.sym_valid, bus.sym_eob, bus.sym_run, bus.sym_value}, {1'b1, held_sym});
      if (bus.sym_valid && bus.sym_ready) begin
        acc_cyc_q.push_back(cyc);
        if (exp_q.size() == 0)
          check("extra_sym", 64'(exp_q.size()), 64'd1);
        else
          check("sym", {bus.sym_eob, bus.sym_run, bus.sym_value}, exp_q.pop_front());
      end
      held     = bus.sym_valid && !bus.sym_ready;
      held_sym = {bus.sym_eob, bus.sym_run, bus.sym_value};
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    bus.sym_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!bp_mode) begin
        bus.sym_ready = 1'b1;
      end else if (!bus.sym_valid) begin
        bus.sym_ready = 1'b1;
        hold_cnt = 0;
      end else if (hold_cnt < 5) begin
        bus.sym_ready = 1'b0;
        hold_cnt++;
      end else begin
        bus.sym_ready = 1'b1;
        hold_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_block(input logic [BW-1:0] blk, output int c_acc);
    int n = 0;
    @(negedge clk);
    while (!bus.block_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(bus.block_ready), 64'd1);
    #1;
    bus.block_in    = blk;
    bus.block_valid = 1'b1;
    @(posedge clk);
    #1;
    c_acc           = cyc;
    bus.block_valid = 1'b0;
    check("busy_set", 64'(busy), 64'd1);
    check("ready_low", 64'(bus.block_ready), 64'd0);
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - start), 64'd1);
    check("leftover_exp", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(bus.sym_valid), 64'd0);
    check({tag, "_run"},   64'(bus.sym_run),   64'd0);
    check({tag, "_value"}, 64'(bus.sym_value), 64'd0);
    check({tag, "_eob"},   64'(bus.sym_eob),   64'd0);
    check({tag, "_done"},  64'(done),          64'd0);
    check({tag, "_busy"},  64'(busy),          64'd0);
    check({tag, "_ready"}, 64'(bus.block_ready), 64'd1);
  endtask

  task automatic push_basic();
    exp_q.push_back(sym(1'b0, 4'd0, 16'd100));
    exp_q.push_back(sym(1'b0, 4'd0, 16'hFFFD));
    exp_q.push_back(sym(1'b0, 4'd3, 16'd7));
    exp_q.push_back(sym(1'b1, 4'd0, 16'd0));
  endtask

  // ---------------- main sequence ----------------
  logic [BW-1:0] basic_blk, zero_blk, long_blk, ones_blk;
  int            c_acc;

  initial begin
    bus.block_valid = 1'b0;
    bus.block_in    = '0;

    basic_blk = '0;
    basic_blk[0*16 +: 16] = 16'd100;
    basic_blk[1*16 +: 16] = 16'hFFFD;
    basic_blk[5*16 +: 16] = 16'd7;
    zero_blk = '0;
    long_blk = '0;
    long_blk[0*16 +: 16]  = 16'd5;
    long_blk[20*16 +: 16] = 16'hFFFF;
    for (int k = 0; k < NUM_SAMPLES; k++) ones_blk[k*16 +: 16] = 16'd1;

    // reset state
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // basic block, full throughput
    push_basic();
    acc_cyc_q.delete();
    send_block(basic_blk, c_acc);
    wait_done(100);
    check("basic_nsym", 64'(acc_cyc_q.size()), 64'd4);
    if (acc_cyc_q.size() == 4) begin
      check("basic_dc_lat", 64'(acc_cyc_q[0] - c_acc), 64'd0);
      check("basic_gap1", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd1);
      check("basic_gap2", 64'(acc_cyc_q[2] - acc_cyc_q[1]), 64'd4);
      check("basic_gap3", 64'(acc_cyc_q[3] - acc_cyc_q[2]), 64'd1);
      check("basic_done_lat", 64'(done_cyc - acc_cyc_q[3]), 64'd1);
    end
    check("basic_rdy_at_done", 64'(rdy_at_done), 64'd1);
    check("basic_busy_at_done", 64'(busy_at_done), 64'd0);

    // all-zero block: DC then EOB on the next cycle
    exp_q.push_back(sym(1'b0, 4'd0, 16'd0));
    exp_q.push_back(sym(1'b1, 4'd0, 16'd0));
    acc_cyc_q.delete();
    send_block(zero_blk, c_acc);
    wait_done(100);
    check("zero_nsym", 64'(acc_cyc_q.size()), 64'd2);
    if (acc_cyc_q.size() == 2)
      check("zero_gap", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd1);

    // long zero run crossing a ZRL boundary
    exp_q.push_back(sym(1'b0, 4'd0, 16'd5));
    exp_q.push_back(sym(1'b0, 4'd15, 16'd0));
    exp_q.push_back(sym(1'b0, 4'd3, 16'hFFFF));
    exp_q.push_back(sym(1'b1, 4'd0, 16'd0));
    acc_cyc_q.delete();
    send_block(long_blk, c_acc);
    wait_done(200);
    check("long_nsym", 64'(acc_cyc_q.size()), 64'd4);
    if (acc_cyc_q.size() == 4) begin
      check("long_zrl_at16", 64'(acc_cyc_q[1] - c_acc), 64'd16);
      check("long_ac_at20", 64'(acc_cyc_q[2] - c_acc), 64'd20);
      check("long_eob_at21", 64'(acc_cyc_q[3] - c_acc), 64'd21);
    end

    // full block of ones: 64 run-0 symbols plus EOB
    for (int k = 0; k < NUM_SAMPLES; k++) exp_q.push_back(sym(1'b0, 4'd0, 16'd1));
    exp_q.push_back(sym(1'b1, 4'd0, 16'd0));
    acc_cyc_q.delete();
    send_block(ones_blk, c_acc);
    wait_done(300);
    check("full_nsym", 64'(acc_cyc_q.size()), 64'd65);
    if (acc_cyc_q.size() == 65) begin
      check("full_span", 64'(acc_cyc_q[64] - acc_cyc_q[0]), 64'd64);
      check("full_done_lat", 64'(done_cyc - acc_cyc_q[64]), 64'd1);
    end

    // backpressure plus an enable stall mid-scan
    bp_mode = 1'b1;
    push_basic();
    acc_cyc_q.delete();
    send_block(basic_blk, c_acc);
    repeat (8) @(negedge clk);
    #1 enable = 1'b0;
    repeat (7) @(negedge clk);
    #1 enable = 1'b1;
    wait_done(500);
    check("stall_nsym", 64'(acc_cyc_q.size()), 64'd4);
    bp_mode = 1'b0;
    repeat (2) @(negedge clk);

    // asynchronous reset after the second symbol
    push_basic();
    acc_cyc_q.delete();
    send_block(basic_blk, c_acc);
    begin
      int n = 0;
      while (acc_cyc_q.size() < 2 && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    check("rst_two_syms", 64'(acc_cyc_q.size()), 64'd2);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;

    // encoder must recover cleanly on the next block
    exp_q.push_back(sym(1'b0, 4'd0, 16'd5));
    exp_q.push_back(sym(1'b0, 4'd15, 16'd0));
    exp_q.push_back(sym(1'b0, 4'd3, 16'hFFFF));
    exp_q.push_back(sym(1'b1, 4'd0, 16'd0));
    acc_cyc_q.delete();
    send_block(long_blk, c_acc);
    wait_done(200);
    check("post_rst_nsym", 64'(acc_cyc_q.size()), 64'd4);
    if (acc_cyc_q.size() == 4)
      check("post_rst_dc_lat", 64'(acc_cyc_q[0] - c_acc), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
